pack_line_sequencer: RTL and testbench

Frame/line sequencer for the pixel-to-AXI packing path in the VDMA write channel. It accepts a pixel stream framed by a frame-sync pulse and generates the packer write/align/last strobes. For each line it issues one write command (address, word count) to the AXI write master, computed from the configured geometry. It also stalls the pixel source whenever a line command cannot be posted.

---
 rtl/pack_line_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_pack_line_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pack_line_sequencer.sv
// pack_line_sequencer: frame/line sequencer for the VDMA write-channel
// pixel packer. It waits for a frame sync and posts one write command per
// line (start address, OSIZE word count). Pixels are then forwarded to the
// packer with align/last strobes. The pixel source is stalled while a line
// command is outstanding.
//
// Optional feature: define SEQ_WORD_CHECK_EN to count packer output words
// per line and flag a mismatch against cmd_words on err_words. Without the
// macro, err_words is tied low.
//
// Handshakes: a pixel transfers on a clock edge where i_valid && i_ready.
// A command transfers on a clock edge where cmd_valid && cmd_ready. While
// cmd_valid is high its fields are held stable. Both ready/valid sides are
// registered outputs of this block.
module pack_line_sequencer #(
    parameter int ISIZE = 24,
    parameter int OSIZE = 256,
    parameter int HBITS = 12,
    parameter int VBITS = 12,
    parameter int AW    = 32
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic [HBITS-1:0] cfg_hactive,
    input  logic [VBITS-1:0] cfg_vactive,
    input  logic [AW-1:0]    cfg_base,
    input  logic [AW-1:0]    cfg_stride,
    input  logic             i_fsync,
    input  logic             i_valid,
    input  logic [ISIZE-1:0] i_data,
    output logic             i_ready,
    output logic             pk_wr_en,
    output logic [ISIZE-1:0] pk_data,
    output logic             pk_align,
    output logic             pk_last,
    input  logic             pk_owr_en,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [AW-1:0]    cmd_addr,
    output logic [HBITS-1:0] cmd_words,
    output logic             busy,
    output logic             frame_done,
    output logic             err_sync,
    output logic             err_words,
    output logic [2:0]       o_dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_FS = 3'd1;
    localparam logic [2:0] S_ALIGN   = 3'd2;
    localparam logic [2:0] S_CMD     = 3'd3;
    localparam logic [2:0] S_LINE    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    // Product width is sized so hactive*ISIZE + OSIZE-1 never overflows.
    localparam int OSH = $clog2(OSIZE);
    localparam int PW  = HBITS + $clog2(ISIZE) + OSH + 1;

    localparam logic [HBITS-1:0] PIX_ONE  = 1;
    localparam logic [VBITS:0]   LINE_ONE = 1;

    logic [2:0]       r_state;
    logic [HBITS-1:0] r_hactive;
    logic [VBITS-1:0] r_vactive;
    logic [AW-1:0]    r_base;
    logic [AW-1:0]    r_stride;
    logic [VBITS:0]   r_line_cnt;
    logic [HBITS-1:0] r_pix_cnt;
    logic             r_i_ready;
    logic             r_pk_wr_en;
    logic [ISIZE-1:0] r_pk_data;
    logic             r_pk_align;
    logic             r_pk_last;
    logic             r_cmd_valid;
    logic [AW-1:0]    r_cmd_addr;
    logic [HBITS-1:0] r_cmd_words;
    logic             r_busy;
    logic             r_frame_done;
    logic             r_err_sync;

    logic [2:0]       w_next_state;
    logic             w_accept;
    logic             w_pix_last;
    logic [VBITS:0]   w_line_next;
    logic             w_frame_last;
    logic [PW-1:0]    w_bits;
    logic [HBITS-1:0] w_words;

    // i_ready is only high in LINE, so this is a LINE-state acceptance.
    assign w_accept     = i_valid && r_i_ready;
    assign w_pix_last   = (r_pix_cnt == (r_hactive - PIX_ONE));
    // Line counter carries one extra bit so the compare never wraps.
    assign w_line_next  = r_line_cnt + LINE_ONE;
    assign w_frame_last = (w_line_next == {1'b0, r_vactive});
    assign w_bits       = PW'(r_hactive) * PW'(ISIZE) + PW'(OSIZE - 1);
    assign w_words      = HBITS'(w_bits >> OSH);

    // Next-state decode of the frame/line sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (enable) w_next_state = S_WAIT_FS;
            S_WAIT_FS: begin
                if (!enable)      w_next_state = S_IDLE;
                else if (i_fsync) w_next_state = S_ALIGN;
            end
            S_ALIGN:   w_next_state = S_CMD;
            S_CMD:     if (cmd_ready) w_next_state = S_LINE;
            S_LINE:    if (w_accept && w_pix_last)
                           w_next_state = w_frame_last ? S_DONE : S_CMD;
            S_DONE:    w_next_state = enable ? S_WAIT_FS : S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // State, registered outputs derived from next state, config and counters.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_hactive    <= '0;
            r_vactive    <= '0;
            r_base       <= '0;
            r_stride     <= '0;
            r_line_cnt   <= '0;
            r_pix_cnt    <= '0;
            r_i_ready    <= 1'b0;
            r_pk_wr_en   <= 1'b0;
            r_pk_data    <= '0;
            r_pk_align   <= 1'b0;
            r_pk_last    <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_words  <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_sync   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_busy       <= (w_next_state != S_IDLE) && (w_next_state != S_WAIT_FS);
            r_i_ready    <= (w_next_state == S_LINE);
            r_cmd_valid  <= (w_next_state == S_CMD);
            r_frame_done <= (w_next_state == S_DONE);
            r_pk_align   <= (r_state == S_WAIT_FS) && (w_next_state == S_ALIGN);
            r_pk_wr_en   <= w_accept;
            r_pk_last    <= w_accept && w_pix_last;
            if (w_accept) r_pk_data <= i_data;

            // Geometry is sampled every WAIT_FS cycle, including the fsync cycle.
            if (r_state == S_WAIT_FS) begin
                r_hactive <= cfg_hactive;
                r_vactive <= cfg_vactive;
                r_base    <= cfg_base;
                r_stride  <= cfg_stride;
            end

            if (r_state == S_ALIGN) begin
                r_line_cnt  <= '0;
                r_cmd_addr  <= r_base;
                r_cmd_words <= w_words;
            end

            if ((r_state == S_CMD) && cmd_ready) r_pix_cnt <= '0;

            if (w_accept) begin
                if (w_pix_last) begin
                    r_pix_cnt  <= '0;
                    r_cmd_addr <= r_cmd_addr + r_stride;
                    r_line_cnt <= w_line_next;
                end else begin
                    r_pix_cnt <= r_pix_cnt + PIX_ONE;
                end
            end

            if (i_fsync && r_busy) r_err_sync <= 1'b1;
        end
    end

    assign i_ready     = r_i_ready;
    assign pk_wr_en    = r_pk_wr_en;
    assign pk_data     = r_pk_data;
    assign pk_align    = r_pk_align;
    assign pk_last     = r_pk_last;
    assign cmd_valid   = r_cmd_valid;
    assign cmd_addr    = r_cmd_addr;
    assign cmd_words   = r_cmd_words;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign err_sync    = r_err_sync;
    assign o_dbg_state = r_state;

`ifdef SEQ_WORD_CHECK_EN
    logic [HBITS-1:0] r_wc_cnt;
    logic [1:0]       r_wc_win;
    logic             r_err_words;
    logic [HBITS-1:0] w_wc_inc;

    assign w_wc_inc = r_wc_cnt + (pk_owr_en ? PIX_ONE : '0);

    // After pk_last a window of up to 3 cycles waits for the packer's
    // closing word. The line is closed by that word, by window expiry, or
    // by the next line's pk_last arriving early.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_wc_cnt    <= '0;
            r_wc_win    <= '0;
            r_err_words <= 1'b0;
        end else if ((r_wc_win != 2'd0) && r_pk_last) begin
            if (r_wc_cnt != r_cmd_words) r_err_words <= 1'b1;
            r_wc_cnt <= pk_owr_en ? PIX_ONE : '0;
            r_wc_win <= 2'd3;
        end else if ((r_wc_win != 2'd0) && pk_owr_en) begin
            if (w_wc_inc != r_cmd_words) r_err_words <= 1'b1;
            r_wc_cnt <= '0;
            r_wc_win <= 2'd0;
        end else if (r_wc_win == 2'd1) begin
            if (r_wc_cnt != r_cmd_words) r_err_words <= 1'b1;
            r_wc_cnt <= '0;
            r_wc_win <= 2'd0;
        end else begin
            r_wc_cnt <= (r_state == S_ALIGN) ? '0 : w_wc_inc;
            if (r_pk_last)              r_wc_win <= 2'd3;
            else if (r_wc_win != 2'd0)  r_wc_win <= r_wc_win - 2'd1;
        end
    end

    assign err_words = r_err_words;
`else
    logic w_unused_owr;
    assign w_unused_owr = pk_owr_en;
    assign err_words    = 1'b0;
`endif

endmodule

// File: tb/tb_pack_line_sequencer.sv
// Bench for pack_line_sequencer: directed scenarios plus randomized frames,
// checked against a geometry-level model (expected command list and pixel
// stream computed from hactive/vactive/base/stride).
module tb_pack_line_sequencer;

    localparam int ISIZE = 24;
    localparam int OSIZE = 256;
    localparam int HBITS = 12;
    localparam int VBITS = 12;
    localparam int AW    = 32;

    logic             clock = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic [HBITS-1:0] cfg_hactive = '0;
    logic [VBITS-1:0] cfg_vactive = '0;
    logic [AW-1:0]    cfg_base = '0;
    logic [AW-1:0]    cfg_stride = '0;
    logic             i_fsync = 1'b0;
    logic             i_valid = 1'b0;
    logic [ISIZE-1:0] i_data = '0;
    logic             i_ready;
    logic             pk_wr_en;
    logic [ISIZE-1:0] pk_data;
    logic             pk_align;
    logic             pk_last;
    logic             pk_owr_en = 1'b0;
    logic             cmd_valid;
    logic             cmd_ready = 1'b0;
    logic [AW-1:0]    cmd_addr;
    logic [HBITS-1:0] cmd_words;
    logic             busy;
    logic             frame_done;
    logic             err_sync;
    logic             err_words;
    logic [2:0]       o_dbg_state;

    pack_line_sequencer #(
        .ISIZE(ISIZE), .OSIZE(OSIZE), .HBITS(HBITS), .VBITS(VBITS), .AW(AW)
    ) dut (
        .clock(clock), .rst(rst), .enable(enable),
        .cfg_hactive(cfg_hactive), .cfg_vactive(cfg_vactive),
        .cfg_base(cfg_base), .cfg_stride(cfg_stride),
        .i_fsync(i_fsync), .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
        .pk_wr_en(pk_wr_en), .pk_data(pk_data), .pk_align(pk_align), .pk_last(pk_last),
        .pk_owr_en(pk_owr_en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
        .busy(busy), .frame_done(frame_done), .err_sync(err_sync), .err_words(err_words),
        .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // scoreboard state
    logic [ISIZE-1:0] exp_q[$];
    logic [ISIZE-1:0] wr_q[$];
    bit               last_q[$];
    logic [AW-1:0]    caddr_q[$];
    logic [HBITS-1:0] cwords_q[$];
    int align_cnt, done_cnt, align_wr_idx, align_conflict;
    int ready_with_cmd, cmd_unstable, stall_ctr, stall_ready;

    // Drive one frame and score it against the geometry model.
    task automatic run_frame(input int h, input int v, input logic [AW-1:0] base,
                             input logic [AW-1:0] stride, input int stall_line,
                             input int stall_cyc, input int fsync_at, input int rst_at,
                             input bit short_owr, input bit rand_hs);
        int total, sent, cmd_idx, post, j, words;
        bit seen_done, fs_done, cmd_pend, exp_err_words;
        logic [AW-1:0]    p_addr, ea;
        logic [HBITS-1:0] p_words;
        exp_q.delete(); wr_q.delete(); last_q.delete(); caddr_q.delete(); cwords_q.delete();
        align_cnt = 0; done_cnt = 0; align_wr_idx = -1; align_conflict = 0;
        ready_with_cmd = 0; cmd_unstable = 0; stall_ctr = 0; stall_ready = 0;
        total = h * v; sent = 0; cmd_idx = 0; post = 0;
        seen_done = 0; fs_done = 0; cmd_pend = 0; p_addr = '0; p_words = '0;
`ifdef SEQ_WORD_CHECK_EN
        exp_err_words = short_owr;
`else
        exp_err_words = 1'b0;
`endif
        for (int i = 0; i < total; i++) exp_q.push_back(ISIZE'($urandom));
        cfg_hactive = HBITS'(h); cfg_vactive = VBITS'(v);
        cfg_base = base; cfg_stride = stride; enable = 1'b1;
        repeat (2) @(negedge clock);
        for (int cyc = 0; cyc < 4000 && post < 6; cyc++) begin
            @(negedge clock);
            if (cmd_pend && (!cmd_valid || cmd_addr !== p_addr || cmd_words !== p_words))
                cmd_unstable++;
            if (pk_wr_en) begin
                wr_q.push_back(pk_data);
                last_q.push_back(pk_last);
            end
            if (pk_align) begin
                align_cnt++;
                if (align_wr_idx < 0) align_wr_idx = wr_q.size();
                if (pk_wr_en) align_conflict++;
            end
            if (frame_done) begin done_cnt++; seen_done = 1; end
            if (i_ready && cmd_valid) ready_with_cmd++;
            if (rst_at >= 0 && i_ready && sent == rst_at) begin
                i_valid = 1'b1; i_data = exp_q[sent]; rst = 1'b1;
                @(negedge clock);
                n_vec++;
                if ({i_ready, pk_wr_en, pk_data, pk_align, pk_last, cmd_valid, cmd_addr,
                     cmd_words, busy, frame_done, err_sync, err_words, o_dbg_state} !== '0) begin
                    n_err++;
                    $display("FAIL rst_mid_outputs: got %h, want 0",
                             {i_ready, pk_wr_en, pk_data, pk_align, pk_last, cmd_valid, cmd_addr,
                              cmd_words, busy, frame_done, err_sync, err_words, o_dbg_state});
                end
                rst = 1'b0; i_valid = 1'b0; cmd_ready = 1'b0; pk_owr_en = 1'b0; i_fsync = 1'b0;
                return;
            end
            // stub packer: one output word per filled OSIZE word, plus a flush word
            pk_owr_en = 1'b0;
            if (pk_wr_en) begin
                j = (wr_q.size() - 1) % h;
                if ((((j + 1) * ISIZE) / OSIZE > (j * ISIZE) / OSIZE) ||
                    (j == h - 1 && (h * ISIZE) % OSIZE != 0))
                    pk_owr_en = !(short_owr && j == h - 1);
            end
            i_fsync = (cyc == 0) || (fsync_at >= 0 && !fs_done && sent == fsync_at && i_ready);
            if (fsync_at >= 0 && sent == fsync_at && i_ready) fs_done = 1;
            i_valid = (sent < total) ? (rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1) : 1'b1;
            i_data  = (sent < total) ? exp_q[sent] : ISIZE'($urandom);
            if (cmd_idx == stall_line && stall_ctr < stall_cyc) begin
                cmd_ready = 1'b0;
                if (cmd_valid) begin
                    stall_ctr++;
                    if (i_ready) stall_ready++;
                end
            end else begin
                cmd_ready = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (i_valid && i_ready) sent++;
            if (cmd_valid && cmd_ready) begin
                caddr_q.push_back(cmd_addr);
                cwords_q.push_back(cmd_words);
                cmd_idx++;
            end
            cmd_pend = cmd_valid && !cmd_ready; p_addr = cmd_addr; p_words = cmd_words;
            if (seen_done) post++;
        end
        i_valid = 1'b0; i_fsync = 1'b0; pk_owr_en = 1'b0; cmd_ready = 1'b0;

        n_vec++;
        if (!seen_done) begin n_err++; $display("FAIL frame_done_timeout: seen %0d, want 1", seen_done); end
        n_vec++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL frame_done_count: got %0d, want 1", done_cnt); end
        n_vec++;
        if (align_cnt !== 1) begin n_err++; $display("FAIL align_count: got %0d, want 1", align_cnt); end
        n_vec++;
        if (align_wr_idx !== 0 || align_conflict !== 0) begin
            n_err++;
            $display("FAIL align_order: writes before align %0d conflicts %0d, want 0 0", align_wr_idx, align_conflict);
        end
        n_vec++;
        if (caddr_q.size() !== v) begin n_err++; $display("FAIL cmd_count: got %0d, want %0d", caddr_q.size(), v); end
        words = (h * ISIZE + OSIZE - 1) / OSIZE;
        for (int k = 0; k < v && k < caddr_q.size(); k++) begin
            ea = base + AW'(k) * stride;
            n_vec++;
            if (caddr_q[k] !== ea || cwords_q[k] !== HBITS'(words)) begin
                n_err++;
                $display("FAIL cmd_%0d: got (%h,%0d), want (%h,%0d)", k, caddr_q[k], cwords_q[k], ea, words);
            end
        end
        n_vec++;
        if (wr_q.size() !== total) begin n_err++; $display("FAIL wr_count: got %0d, want %0d", wr_q.size(), total); end
        for (int i = 0; i < total && i < wr_q.size(); i++) begin
            n_vec++;
            if (wr_q[i] !== exp_q[i] || last_q[i] !== (i % h == h - 1)) begin
                n_err++;
                $display("FAIL pixel_%0d: got %h last %0d, want %h last %0d",
                         i, wr_q[i], last_q[i], exp_q[i], (i % h == h - 1));
            end
        end
        n_vec++;
        if (ready_with_cmd !== 0) begin n_err++; $display("FAIL ready_during_cmd: got %0d cycles, want 0", ready_with_cmd); end
        n_vec++;
        if (cmd_unstable !== 0) begin n_err++; $display("FAIL cmd_stable: got %0d changes, want 0", cmd_unstable); end
        n_vec++;
        if (err_words !== exp_err_words) begin n_err++; $display("FAIL err_words: got %0d, want %0d", err_words, exp_err_words); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clock);
        n_vec++;
        if ({i_ready, pk_wr_en, pk_data, pk_align, pk_last, cmd_valid, cmd_addr,
             cmd_words, busy, frame_done, err_sync, err_words, o_dbg_state} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, want 0",
                     {i_ready, pk_wr_en, pk_data, pk_align, pk_last, cmd_valid, cmd_addr,
                      cmd_words, busy, frame_done, err_sync, err_words, o_dbg_state});
        end
        rst = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        run_frame(32, 2, 32'h1000, 32'h400, -1, 0, -1, -1, 1'b0, 1'b0);
        n_vec++;
        if (err_sync !== 1'b0) begin n_err++; $display("FAIL basic_err_sync: got %0d, want 0", err_sync); end
    endtask

    task automatic test_cmd_stall();
        run_frame(32, 2, 32'h1000, 32'h400, 1, 10, -1, -1, 1'b0, 1'b0);
        n_vec++;
        if (stall_ctr !== 10 || stall_ready !== 0) begin
            n_err++;
            $display("FAIL stall: held %0d ready-cycles %0d, want 10 0", stall_ctr, stall_ready);
        end
    endtask

    task automatic test_fsync_mid();
        run_frame(32, 2, 32'h1000, 32'h400, -1, 0, 16, -1, 1'b0, 1'b0);
        n_vec++;
        if (err_sync !== 1'b1) begin n_err++; $display("FAIL fsync_mid_err_sync: got %0d, want 1", err_sync); end
    endtask

    task automatic test_rst_mid();
        run_frame(32, 2, 32'h1000, 32'h400, -1, 0, -1, 10, 1'b0, 1'b0);
        run_frame(32, 2, 32'h1000, 32'h400, -1, 0, -1, -1, 1'b0, 1'b0);
        n_vec++;
        if (err_sync !== 1'b0) begin n_err++; $display("FAIL rst_clears_err_sync: got %0d, want 0", err_sync); end
    endtask

    task automatic test_hactive1();
        run_frame(1, 3, 32'h2000, 32'h80, -1, 0, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_enable_idle();
        int bad;
        bad = 0;
        enable = 1'b0;
        repeat (3) @(negedge clock);
        i_fsync = 1'b1;
        @(negedge clock);
        i_fsync = 1'b0;
        repeat (5) begin
            if (busy || cmd_valid || pk_align || o_dbg_state !== 3'd0) bad++;
            @(negedge clock);
        end
        n_vec++;
        if (bad !== 0) begin n_err++; $display("FAIL enable_low_fsync: got %0d active cycles, want 0", bad); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 5; n++)
            run_frame($urandom_range(1, 40), $urandom_range(1, 3), AW'($urandom),
                      {AW'($urandom_range(0, 255)) << 6}, -1, 0, -1, -1, 1'b0, 1'b1);
    endtask

    task automatic test_word_check();
        run_frame(32, 2, 32'h1000, 32'h400, -1, 0, -1, -1, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cmd_stall();
        test_fsync_mid();
        test_rst_mid();
        test_hactive1();
        test_enable_idle();
        test_random();
        test_word_check();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
